// File: rtl/datapath_sched_pkg.sv
// Shared types and constants for the datapath scheduler: FSM states, select widths
// and the fixed per-step datapath control table.
package datapath_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int SEL_CONST_W = 3;
   localparam int SEL_FUN_W   = 2;
   localparam int SEL_ACUM_W  = 2;
   localparam int STEP_W      = 3;

   typedef struct packed {
      logic [SEL_CONST_W-1:0] sel_const;
      logic [SEL_ACUM_W-1:0]  sel_acum;
      logic [SEL_FUN_W-1:0]   sel_fun;
      logic                   senal;
   } step_t;

   localparam step_t STEP_0 = '{sel_const: 3'd0, sel_acum: 2'd0, sel_fun: 2'd0, senal: 1'b0};
   localparam step_t STEP_1 = '{sel_const: 3'd0, sel_acum: 2'd1, sel_fun: 2'd2, senal: 1'b0};
   localparam step_t STEP_2 = '{sel_const: 3'd1, sel_acum: 2'd1, sel_fun: 2'd3, senal: 1'b1};
   localparam step_t STEP_3 = '{sel_const: 3'd2, sel_acum: 2'd2, sel_fun: 2'd1, senal: 1'b0};
   localparam step_t STEP_4 = '{sel_const: 3'd3, sel_acum: 2'd1, sel_fun: 2'd2, senal: 1'b0};
   localparam step_t STEP_5 = '{sel_const: 3'd4, sel_acum: 2'd1, sel_fun: 2'd3, senal: 1'b0};

   // Steps beyond the six defined entries drive an idle (all-zero) control word.
   function automatic step_t step_lookup(input logic [STEP_W-1:0] step);
      step_t entry;
      entry = '0;
      case (step)
         3'd0:    entry = STEP_0;
         3'd1:    entry = STEP_1;
         3'd2:    entry = STEP_2;
         3'd3:    entry = STEP_3;
         3'd4:    entry = STEP_4;
         3'd5:    entry = STEP_5;
         default: entry = '0;
      endcase
      return entry;
   endfunction

endpackage

// File: rtl/sched_arbiter.sv
// Picks the next owner among requesters. Define DATAPATH_SCHED_RR_EN for round-robin
// with a rotating pointer; otherwise the lowest-index requester always wins.
module sched_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               take,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

`ifdef DATAPATH_SCHED_RR_EN
   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] rotated;
   logic [IDX_W:0]     sum;

   // Pointer moves just past the requester that is being granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (take) begin
         ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   // Rotate so the search begins at the pointer, then map the offset back.
   always_comb begin
      rotated = NUM_REQ'({req, req} >> ptr);
      any     = 1'b0;
      sum     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && rotated[i]) begin
            any = 1'b1;
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         end
      end
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
         sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      winner = sum[IDX_W-1:0];
   end
`else
   logic unused_inputs;
   assign unused_inputs = ^{clk, reset, take};

   always_comb begin
      any    = |req;
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner = IDX_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/datapath_scheduler.sv
// Grants a shared datapath to one requester and steps it through a fixed control
// sequence. Arbitration is round-robin when DATAPATH_SCHED_RR_EN is defined.
module datapath_scheduler
   import datapath_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int SEQ_LEN = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [2:0]         sel_const,
   output logic [1:0]         sel_fun,
   output logic [1:0]         sel_acum,
   output logic               senal,
   output logic [NUM_REQ-1:0] done,
   output logic               abort,
   output logic               busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

   state_t             state, state_next;
   logic [STEP_W-1:0]  step, step_next;
   logic [IDX_W-1:0]   owner, owner_next;
   logic [IDX_W-1:0]   winner;
   logic               any_req;
   logic               take;
   logic               owner_live;
   logic [NUM_REQ-1:0] owner_onehot;
   step_t              cur_step;

   sched_arbiter #(
      .NUM_REQ(NUM_REQ),
      .IDX_W  (IDX_W)
   ) u_arbiter (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .take  (take),
      .winner(winner),
      .any   (any_req)
   );

   assign owner_live   = req[owner];
   assign owner_onehot = NUM_REQ'(1) << owner;
   assign cur_step     = step_lookup(step);
   assign busy         = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         step  <= '0;
         owner <= '0;
      end else begin
         state <= state_next;
         step  <= step_next;
         owner <= owner_next;
      end
   end

   // Losing the owner's request before DONE abandons the job; in DONE it is ignored.
   always_comb begin
      state_next = state;
      step_next  = step;
      owner_next = owner;
      take       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_next = ST_GRANT;
               owner_next = winner;
               take       = 1'b1;
            end
         end
         ST_GRANT: begin
            step_next = '0;
            if (owner_live) begin
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!owner_live) begin
               state_next = ST_IDLE;
               step_next  = '0;
            end else if (step == LAST_STEP) begin
               state_next = ST_DONE;
               step_next  = '0;
            end else begin
               step_next = step + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      gnt       = '0;
      sel_const = '0;
      sel_fun   = '0;
      sel_acum  = '0;
      senal     = 1'b0;
      done      = '0;
      abort     = 1'b0;
      unique case (state)
         ST_GRANT: begin
            if (owner_live) begin
               gnt = owner_onehot;
            end else begin
               abort = 1'b1;
            end
         end
         ST_RUN: begin
            if (owner_live) begin
               gnt       = owner_onehot;
               sel_const = cur_step.sel_const;
               sel_fun   = cur_step.sel_fun;
               sel_acum  = cur_step.sel_acum;
               senal     = cur_step.senal;
            end else begin
               abort = 1'b1;
            end
         end
         ST_DONE: begin
            gnt  = owner_onehot;
            done = owner_onehot;
         end
         default: begin
         end
      endcase
   end

endmodule
